// File: rtl/vector_loader_pkg.sv
// vector_loader_pkg: shared loader types and constants (lane count, constant count, word width, FSM states)
package vector_loader_pkg;
  localparam int LANES = 4;
  localparam int N_COEF = 8;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [2:0] {IDLE, MUL_RD, MUL_FILL, MUL_WR, PIX_RD, PIX_FILL, PIX_WR, DONE} loader_state_t;
endpackage

// File: rtl/vector_pixel_loader_if.sv
// vector_pixel_loader_if: CPU external load port (ready in; we_mul/wr_mul_pos_in/wdm1..4 and we_pxl/wr_pos_pxl/wdp1..4 out of master)
interface vector_pixel_loader_if;
  import vector_loader_pkg::*;
  logic ready, we_mul, wr_mul_pos_in, we_pxl, wr_pos_pxl;
  word_t wdm1, wdm2, wdm3, wdm4, wdp1, wdp2, wdp3, wdp4;
  modport master(
    input ready,
    output we_mul, wr_mul_pos_in, wdm1, wdm2, wdm3, wdm4, we_pxl, wr_pos_pxl, wdp1, wdp2, wdp3, wdp4
  );
  modport slave(
    output ready,
    input we_mul, wr_mul_pos_in, wdm1, wdm2, wdm3, wdm4, we_pxl, wr_pos_pxl, wdp1, wdp2, wdp3, wdp4
  );
endinterface

// File: rtl/lane_gather.sv
// lane_gather: four lane registers; en writes d into lane[idx], clr synchronously zeroes all lanes
module lane_gather
  import vector_loader_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] idx,
  input  word_t      d,
  output word_t      lane [LANES]
);
  word_t lane_q [LANES];
  word_t lane_d [LANES];
  always_comb begin
    lane_d = lane_q;
    if (en) lane_d[idx] = d;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++) lane_q[i] <= clr ? '0 : lane_d[i];
  assign lane = lane_q;
endmodule

// File: rtl/vector_pixel_loader.sv
// vector_pixel_loader: reads 8 constants then N_PIX pixels from src_* memory on start, emits 4-lane beats on lp, busy/done status
module vector_pixel_loader
  import vector_loader_pkg::*;
#(
  parameter int N_PIX     = 64,
  parameter int PIX_BASE  = 0,
  parameter int COEF_BASE = 1024,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  word_t             src_data,
  output logic              busy,
  output logic              done,
  vector_pixel_loader_if.master lp
);
  localparam int N_GRP = N_PIX / LANES;
  localparam int GW = $clog2(N_GRP) + 1;
  loader_state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [1:0] k_q, k_d;
  logic is_mul, rd, fill, last, we_m, we_p;
  logic [ADDR_W-1:0] base;
  word_t lane [LANES];
  always_comb begin
    is_mul = state_q inside {MUL_RD, MUL_FILL, MUL_WR};
    rd = state_q inside {MUL_RD, PIX_RD};
    fill = state_q inside {MUL_FILL, PIX_FILL};
    last = g_q == (is_mul ? GW'(N_COEF / LANES - 1) : GW'(N_GRP - 1));
    base = is_mul ? ADDR_W'(COEF_BASE) : ADDR_W'(PIX_BASE);
  end
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = MUL_RD;
        g_d = '0;
        k_d = '0;
      end
      MUL_RD, PIX_RD: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = is_mul ? MUL_FILL : PIX_FILL;
      end
      MUL_FILL: state_d = MUL_WR;
      PIX_FILL: state_d = PIX_WR;
      MUL_WR, PIX_WR: if (lp.ready) begin
        state_d = last ? (is_mul ? PIX_RD : DONE) : (is_mul ? MUL_RD : PIX_RD);
        g_d = last ? '0 : g_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      k_q <= k_d;
    end
  // read data lags the strobe by one cycle, so lane k-1 is captured while lane k is requested; FILL catches lane 3
  lane_gather u_gather (
    .clk (clk),
    .clr (rst),
    .en  (fill || (rd && k_q != 2'd0)),
    .idx (k_q - 2'd1),
    .d   (src_data),
    .lane(lane)
  );
  assign src_rd = rd;
  assign src_addr = rd ? base + ADDR_W'({g_q, k_q}) : '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign we_m = state_q == MUL_WR;
  assign we_p = state_q == PIX_WR;
  assign lp.we_mul = we_m;
  assign lp.we_pxl = we_p;
  assign lp.wr_mul_pos_in = we_m & g_q[0];
  assign lp.wr_pos_pxl = we_p & g_q[0];
  assign lp.wdm1 = we_m ? lane[0] : '0;
  assign lp.wdm2 = we_m ? lane[1] : '0;
  assign lp.wdm3 = we_m ? lane[2] : '0;
  assign lp.wdm4 = we_m ? lane[3] : '0;
  assign lp.wdp1 = we_p ? lane[0] : '0;
  assign lp.wdp2 = we_p ? lane[1] : '0;
  assign lp.wdp3 = we_p ? lane[2] : '0;
  assign lp.wdp4 = we_p ? lane[3] : '0;
endmodule

// File: tb/tb_vector_pixel_loader.sv
// tb_vector_pixel_loader: scoreboard bench for vector_pixel_loader (main instance N_PIX=8, wrap instance ADDR_W=4)
module tb_vector_pixel_loader;
  import vector_loader_pkg::*;
  typedef struct packed {
    logic pxl;
    logic pos;
    logic [31:0] w1, w2, w3, w4;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int xfer [2];
  beat_t qs [2][$];
  logic [3:0] addr_b [$];
  logic src_rd_a, busy_a, done_a, src_rd_b, busy_b, done_b;
  logic [15:0] src_addr_a;
  logic [3:0] src_addr_b;
  word_t src_data_a = '0;
  word_t src_data_b = '0;
  vector_pixel_loader_if lpa ();
  vector_pixel_loader_if lpb ();
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (src_rd_a) src_data_a <= {16'h0, src_addr_a};
  always @(posedge clk) if (src_rd_b) src_data_b <= 32'hB0 + {28'h0, src_addr_b};
  vector_pixel_loader #(.N_PIX(8), .PIX_BASE(0), .COEF_BASE(1024), .ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .src_rd(src_rd_a), .src_addr(src_addr_a),
    .src_data(src_data_a), .busy(busy_a), .done(done_a), .lp(lpa)
  );
  vector_pixel_loader #(.N_PIX(4), .PIX_BASE(14), .COEF_BASE(1024), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .src_rd(src_rd_b), .src_addr(src_addr_b),
    .src_data(src_data_b), .busy(busy_b), .done(done_b), .lp(lpb)
  );
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mon(input int id, input logic wm, input logic wp, input logic pm, input logic pp, input logic rdy,
                     input word_t m1, input word_t m2, input word_t m3, input word_t m4,
                     input word_t p1, input word_t p2, input word_t p3, input word_t p4);
    beat_t o, e;
    if (wm || wp) chk($sformatf("excl%0d", id), 160'(wm & wp), 160'(0));
    if ((wm || wp) && rdy) begin
      xfer[id]++;
      o.pxl = wp;
      o.pos = wp ? pp : pm;
      o.w1 = wp ? p1 : m1;
      o.w2 = wp ? p2 : m2;
      o.w3 = wp ? p3 : m3;
      o.w4 = wp ? p4 : m4;
      chk($sformatf("beat_avail%0d", id), 160'(qs[id].size() != 0), 160'(1));
      if (qs[id].size() != 0) begin
        e = qs[id].pop_front();
        chk($sformatf("beat%0d", id), 160'(o), 160'(e));
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, lpa.we_mul, lpa.we_pxl, lpa.wr_mul_pos_in, lpa.wr_pos_pxl, lpa.ready,
        lpa.wdm1, lpa.wdm2, lpa.wdm3, lpa.wdm4, lpa.wdp1, lpa.wdp2, lpa.wdp3, lpa.wdp4);
    mon(1, lpb.we_mul, lpb.we_pxl, lpb.wr_mul_pos_in, lpb.wr_pos_pxl, lpb.ready,
        lpb.wdm1, lpb.wdm2, lpb.wdm3, lpb.wdm4, lpb.wdp1, lpb.wdp2, lpb.wdp3, lpb.wdp4);
    if (src_rd_b) addr_b.push_back(src_addr_b);
  end
  task automatic push_a();
    beat_t e;
    for (int g = 0; g < 2; g++) begin
      e.pxl = 1'b0;
      e.pos = 1'(g);
      e.w1 = 32'(1024 + 4 * g);
      e.w2 = 32'(1025 + 4 * g);
      e.w3 = 32'(1026 + 4 * g);
      e.w4 = 32'(1027 + 4 * g);
      qs[0].push_back(e);
    end
    for (int g = 0; g < 2; g++) begin
      e.pxl = 1'b1;
      e.pos = 1'(g);
      e.w1 = 32'(4 * g);
      e.w2 = 32'(4 * g + 1);
      e.w3 = 32'(4 * g + 2);
      e.w4 = 32'(4 * g + 3);
      qs[0].push_back(e);
    end
  endtask
  task automatic start_frame_a(output int x0);
    push_a();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    x0 = xfer[0];
  endtask
  // mode 0: ready=1; 1: ready low in cycles 18..20; 2: random ready; 3: extra start pulses; 4: ready low from cycle 6
  task automatic run_a(input int mode, input int stop_at, output int done_at);
    done_at = -1;
    for (int c = 1; c <= 400; c++) begin
      lpa.ready = mode == 1 ? !(c >= 18 && c <= 20) : mode == 2 ? ($urandom_range(0, 2) != 0) :
                  mode == 4 ? (c < 6) : 1'b1;
      start_a = (mode == 3) && (c == 5 || c == 12);
      @(negedge clk);
      if (c == 1) chk("busy_c1", 160'(busy_a), 160'(1));
      if (c == 1) chk("rd_c1", 160'({src_rd_a, src_addr_a}), 160'({1'b1, 16'd1024}));
      if (mode == 1 && c >= 18 && c <= 21)
        chk($sformatf("hold_c%0d", c), 160'({lpa.we_pxl, lpa.wr_pos_pxl, lpa.wdp1, lpa.wdp2, lpa.wdp3, lpa.wdp4}),
            160'({1'b1, 1'b0, 32'd0, 32'd1, 32'd2, 32'd3}));
      if (c == stop_at) return;
      if (done_a) begin
        done_at = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;
  endtask
  task automatic end_a(input string tag, input int x0);
    chk({tag, "_left"}, 160'(qs[0].size()), 160'(0));
    chk({tag, "_xfers"}, 160'(xfer[0] - x0), 160'(4));
    @(posedge clk);
    #1;
    chk({tag, "_busy_after"}, 160'({busy_a, done_a}), 160'(0));
  endtask
  initial begin
    int d, x0;
    beat_t e;
    xfer[0] = 0;
    xfer[1] = 0;
    lpa.ready = 1'b1;
    lpb.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl_a", 160'({src_rd_a, src_addr_a, busy_a, done_a, lpa.we_mul, lpa.we_pxl, lpa.wr_mul_pos_in, lpa.wr_pos_pxl}), 160'(0));
    chk("rst_lanes_a", 160'({lpa.wdm1, lpa.wdm2, lpa.wdm3, lpa.wdm4}), 160'(0));
    chk("rst_pix_a", 160'({lpa.wdp1, lpa.wdp2, lpa.wdp3, lpa.wdp4}), 160'(0));
    chk("rst_ctl_b", 160'({src_rd_b, src_addr_b, busy_b, done_b, lpb.we_mul, lpb.we_pxl}), 160'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_frame_a(x0);
    run_a(0, 0, d);
    chk("done_basic", 160'(d), 160'(25));
    end_a("basic", x0);
    start_frame_a(x0);
    run_a(1, 0, d);
    chk("done_backpressure", 160'(d), 160'(28));
    end_a("bp", x0);
    start_frame_a(x0);
    run_a(3, 0, d);
    chk("done_start_busy", 160'(d), 160'(25));
    end_a("sbusy", x0);
    start_frame_a(x0);
    run_a(4, 6, d);
    chk("mul_wr_pre_rst", 160'({lpa.we_mul, lpa.wr_mul_pos_in, lpa.wdm1}), 160'({1'b1, 1'b0, 32'd1024}));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_ctl", 160'({src_rd_a, src_addr_a, busy_a, done_a, lpa.we_mul, lpa.we_pxl, lpa.wr_mul_pos_in, lpa.wr_pos_pxl}), 160'(0));
    chk("post_rst_lanes", 160'({lpa.wdm1, lpa.wdm2, lpa.wdm3, lpa.wdm4, lpa.wdp1}), 160'(0));
    chk("post_rst_xfers", 160'(xfer[0] - x0), 160'(0));
    qs[0].delete();
    start_frame_a(x0);
    run_a(0, 0, d);
    chk("done_after_rst", 160'(d), 160'(25));
    end_a("after_rst", x0);
    for (int g = 0; g < 2; g++) begin
      e.pxl = 1'b0;
      e.pos = 1'(g);
      e.w1 = 32'hB0 + 32'(4 * g);
      e.w2 = 32'hB1 + 32'(4 * g);
      e.w3 = 32'hB2 + 32'(4 * g);
      e.w4 = 32'hB3 + 32'(4 * g);
      qs[1].push_back(e);
    end
    e.pxl = 1'b1;
    e.pos = 1'b0;
    e.w1 = 32'hBE;
    e.w2 = 32'hBF;
    e.w3 = 32'hB0;
    e.w4 = 32'hB1;
    qs[1].push_back(e);
    addr_b.delete();
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    d = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done_b) begin
        d = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("done_wrap", 160'(d), 160'(19));
    chk("wrap_left", 160'(qs[1].size()), 160'(0));
    chk("wrap_reads", 160'(addr_b.size()), 160'(12));
    for (int i = 0; i < 12 && i < addr_b.size(); i++)
      chk($sformatf("wrap_addr%0d", i), 160'(addr_b[i]), 160'(i < 8 ? i : (6 + i) % 16));
    @(posedge clk);
    #1;
    for (int f = 0; f < 20; f++) begin
      start_frame_a(x0);
      run_a(2, 0, d);
      chk($sformatf("rand_done%0d", f), 160'(d > 0), 160'(1));
      end_a($sformatf("rand%0d", f), x0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
